// File: rtl/my_col_buffer_pkg.sv
// Shared definitions for the column buffer and its sorter: default frame geometry,
// read-FSM state encodings and bank-select encodings.
package my_col_buffer_pkg;

    localparam int unsigned COL_N  = 40;
    localparam int unsigned COL_W  = 14;
    localparam int unsigned COL_CW = 16;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_BUSY = 2'd1,
        R_GAP  = 2'd2
    } rd_state_e;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_e;

    function automatic bank_sel_e other_bank(input bank_sel_e b);
        bank_sel_e r;
        if (b == BANK_A) begin
            r = BANK_B;
        end else begin
            r = BANK_A;
        end
        return r;
    endfunction

endpackage

// File: rtl/my_col_bank.sv
// One N x W sample bank: single write port, synchronous scrub, flattened read bus
// (element i at bits [i*W +: W]).
module my_col_bank #(
    parameter int N  = 40,
    parameter int W  = 14,
    parameter int IW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            srst,
    input  logic            we,
    input  logic [IW-1:0]   idx,
    input  logic [W-1:0]    wdata,
    output logic [N*W-1:0]  rdata
);

    logic [N-1:0][W-1:0] mem_r;

    // Sample storage; scrub wins over a write so a consumed frame never lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
        end else if (srst) begin
            mem_r <= '0;
        end else if (we) begin
            mem_r[idx] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign rdata = mem_r;

endmodule

// File: rtl/my_col_buffer.sv
// Ping-pong column frame buffer feeding my_sort: fills one bank serially while the
// other bank is presented in parallel with a level sort_start handshake.
module my_col_buffer
    import my_col_buffer_pkg::*;
#(
    parameter int N  = COL_N,
    parameter int W  = COL_W,
    parameter int CW = COL_CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic [N*W-1:0]  data,
    output logic            sort_start,
    input  logic            sort_finish,
    output logic [CW-1:0]   frame_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    rd_state_e        state_r;
    rd_state_e        state_nxt_s;
    bank_sel_e        wr_bank_r;
    bank_sel_e        rd_bank_s;
    logic [1:0]       full_r;
    logic [1:0]       full_nxt_s;
    logic [IW-1:0]    wr_idx_r;
    logic [CW-1:0]    frame_cnt_r;
    logic             sort_start_r;
    logic             accept_s;
    logic             last_s;
    logic             swap_s;
    logic             free_s;
    logic             we_a_s;
    logic             we_b_s;
    logic             clr_a_s;
    logic             clr_b_s;
    logic [N*W-1:0]   rdata_a_s;
    logic [N*W-1:0]   rdata_b_s;

    assign rd_bank_s = other_bank(wr_bank_r);
    assign in_ready  = ~full_r[wr_bank_r];
    assign accept_s  = in_valid & in_ready;
    assign last_s    = accept_s & (wr_idx_r == IW'(N - 1));

    assign we_a_s  = accept_s & (wr_bank_r == BANK_A);
    assign we_b_s  = accept_s & (wr_bank_r == BANK_B);
    // A bank released by the sorter is scrubbed; it is never the write bank at that moment.
    assign clr_a_s = free_s & (rd_bank_s == BANK_A);
    assign clr_b_s = free_s & (rd_bank_s == BANK_B);

    my_col_bank #(.N(N), .W(W), .IW(IW)) u_bank_a (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (clr_a_s),
        .we    (we_a_s),
        .idx   (wr_idx_r),
        .wdata (in_data),
        .rdata (rdata_a_s)
    );

    my_col_bank #(.N(N), .W(W), .IW(IW)) u_bank_b (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (clr_b_s),
        .we    (we_b_s),
        .idx   (wr_idx_r),
        .wdata (in_data),
        .rdata (rdata_b_s)
    );

    // Read FSM next state and the swap/free strobes it issues.
    always_comb begin
        state_nxt_s = state_r;
        swap_s      = 1'b0;
        free_s      = 1'b0;
        case (state_r)
            R_IDLE: begin
                if (full_r[wr_bank_r]) begin
                    swap_s      = 1'b1;
                    state_nxt_s = R_BUSY;
                end else begin
                    state_nxt_s = R_IDLE;
                end
            end
            R_BUSY: begin
                if (sort_finish) begin
                    free_s      = 1'b1;
                    state_nxt_s = R_GAP;
                end else begin
                    state_nxt_s = R_BUSY;
                end
            end
            R_GAP: begin
                state_nxt_s = R_IDLE;
            end
            default: begin
                state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Full-flag update: a completed frame sets its bank; free or swap clears the read bank.
    always_comb begin
        full_nxt_s = full_r;
        if (last_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (free_s || swap_s) begin
            full_nxt_s[rd_bank_s] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_s] = full_r[rd_bank_s];
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= R_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bank roles and full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r <= BANK_A;
            full_r    <= 2'b00;
        end else begin
            if (swap_s) begin
                wr_bank_r <= rd_bank_s;
            end else begin
                wr_bank_r <= wr_bank_r;
            end
            full_r <= full_nxt_s;
        end
    end

    // Write index into the current write bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_r <= '0;
        end else if (last_s) begin
            wr_idx_r <= '0;
        end else if (accept_s) begin
            wr_idx_r <= wr_idx_r + IW'(1);
        end else begin
            wr_idx_r <= wr_idx_r;
        end
    end

    // sort_start level and handed-frame counter; sort_start mirrors R_BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sort_start_r <= 1'b0;
            frame_cnt_r  <= '0;
        end else if (swap_s) begin
            sort_start_r <= 1'b1;
            frame_cnt_r  <= frame_cnt_r + CW'(1);
        end else if (free_s) begin
            sort_start_r <= 1'b0;
            frame_cnt_r  <= frame_cnt_r;
        end else begin
            sort_start_r <= sort_start_r;
            frame_cnt_r  <= frame_cnt_r;
        end
    end

    assign data       = (rd_bank_s == BANK_A) ? rdata_a_s : rdata_b_s;
    assign sort_start = sort_start_r;
    assign frame_cnt  = frame_cnt_r;

endmodule
